// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Data-memory handshake states
    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StWait = 2'd1,
        StErr  = 2'd2
    } memfsm_t;

    // Operand-mux selects for the E-stage forwarding muxes
    localparam logic [1:0] FwdRf = 2'b00;
    localparam logic [1:0] FwdW  = 2'b01;
    localparam logic [1:0] FwdM  = 2'b10;

    // E-stage forward select for one source operand; M has priority over W, $0 never forwards
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wr_m,
                                           input logic       rw_m,
                                           input logic [4:0] wr_w,
                                           input logic       rw_w);
        logic [1:0] sel;
        sel = FwdRf;
        if (src != 5'd0 && src == wr_m && rw_m) begin
            sel = FwdM;
        end else if (src != 5'd0 && src == wr_w && rw_w) begin
            sel = FwdW;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding selects for the E-stage ALU operands and D-stage branch comparator.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] write_reg_m_i,
    input  logic [4:0] write_reg_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] forward_ae_o,
    output logic [1:0] forward_be_o,
    output logic       forward_ad_o,
    output logic       forward_bd_o
);

    // Operand selects from register specifiers of the older in-flight instructions
    always_comb begin
        forward_ae_o = fwd_sel(rs_e_i, write_reg_m_i, reg_write_m_i, write_reg_w_i, reg_write_w_i);
        forward_be_o = fwd_sel(rt_e_i, write_reg_m_i, reg_write_m_i, write_reg_w_i, reg_write_w_i);
        forward_ad_o = (rs_d_i != 5'd0) && (rs_d_i == write_reg_m_i) && reg_write_m_i;
        forward_bd_o = (rt_d_i != 5'd0) && (rt_d_i == write_reg_m_i) && reg_write_m_i;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: forwarding, load-use/branch stalls, data-memory wait FSM with
// timeout trap, and a saturating stalled-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MemTimeout = 255,
    parameter int unsigned Cw         = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [4:0]    rs_d_i,
    input  logic [4:0]    rt_d_i,
    input  logic [4:0]    rs_e_i,
    input  logic [4:0]    rt_e_i,
    input  logic [4:0]    write_reg_e_i,
    input  logic [4:0]    write_reg_m_i,
    input  logic [4:0]    write_reg_w_i,
    input  logic          reg_write_e_i,
    input  logic          reg_write_m_i,
    input  logic          reg_write_w_i,
    input  logic          mem_to_reg_e_i,
    input  logic          mem_to_reg_m_i,
    input  logic          branch_d_i,
    input  logic          pc_src_d_i,
    input  logic          mem_req_m_i,
    input  logic          mem_ready_m_i,
    output logic          stall_f_o,
    output logic          stall_d_o,
    output logic          stall_e_o,
    output logic          stall_m_o,
    output logic          flush_e_o,
    output logic          reg_clr_d_o,
    output logic          flush_w_o,
    output logic [1:0]    forward_ae_o,
    output logic [1:0]    forward_be_o,
    output logic          forward_ad_o,
    output logic          forward_bd_o,
    output logic          mem_err_o,
    output logic [Cw-1:0] stall_count_o
);

    localparam int unsigned WaitW = (MemTimeout < 1) ? 1 : $clog2(MemTimeout + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MemTimeout);
    localparam logic [Cw-1:0] CountMax = {Cw{1'b1}};

    memfsm_t          state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [Cw-1:0]    stall_count_q, stall_count_d;
    logic             mem_err_q, mem_err_d;

    logic lwstall;
    logic brstall;
    logic memstall;
    logic pipe_stall;

    forward_unit u_forward_unit (
        .rs_d_i        (rs_d_i),
        .rt_d_i        (rt_d_i),
        .rs_e_i        (rs_e_i),
        .rt_e_i        (rt_e_i),
        .write_reg_m_i (write_reg_m_i),
        .write_reg_w_i (write_reg_w_i),
        .reg_write_m_i (reg_write_m_i),
        .reg_write_w_i (reg_write_w_i),
        .forward_ae_o  (forward_ae_o),
        .forward_be_o  (forward_be_o),
        .forward_ad_o  (forward_ad_o),
        .forward_bd_o  (forward_bd_o)
    );

    // Raw specifier compares: a conservative stall on $0 is harmless
    always_comb begin
        lwstall = mem_to_reg_e_i & ((rs_d_i == rt_e_i) | (rt_d_i == rt_e_i));
        brstall = branch_d_i &
                  ((reg_write_e_i & ((write_reg_e_i == rs_d_i) | (write_reg_e_i == rt_d_i))) |
                   (mem_to_reg_m_i & ((write_reg_m_i == rs_d_i) | (write_reg_m_i == rt_d_i))));
        pipe_stall = lwstall | brstall;
    end

    // Memory stall depends on handshake state; ERR freezes the pipeline for good
    always_comb begin
        memstall = 1'b0;
        unique case (state_q)
            StRun:   memstall = mem_req_m_i & ~mem_ready_m_i;
            StWait:  memstall = ~mem_ready_m_i;
            StErr:   memstall = 1'b1;
            default: memstall = 1'b0;
        endcase
    end

    // Pipeline controls: a memory stall freezes every stage and beats load-use/branch stalls
    always_comb begin
        if (memstall) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
            flush_e_o = 1'b0;
        end else begin
            stall_f_o = pipe_stall;
            stall_d_o = pipe_stall;
            flush_e_o = pipe_stall;
            stall_e_o = 1'b0;
            stall_m_o = 1'b0;
            flush_w_o = 1'b0;
        end
        // A held branch must stay in D, so no clear while D is stalled
        reg_clr_d_o = pc_src_d_i & ~stall_d_o;
    end

    // Handshake FSM next state and wait-cycle counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_req_m_i && !mem_ready_m_i) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StWait: begin
                if (mem_ready_m_i) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitMax) begin
                    state_d = StErr;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StRun;
        endcase
        mem_err_d = (state_d == StErr);
    end

    // Stalled-cycle counter saturates instead of wrapping
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_f_o && stall_count_q != CountMax) begin
            stall_count_d = stall_count_q + Cw'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign mem_err_o     = mem_err_q;
    assign stall_count_o = stall_count_q;

endmodule
